// File: rtl/count_pkg.sv
// Shared types and default sizes for the counter sequencer and its datapath.
package count_pkg;

  localparam int WIDTH_DEF    = 3;
  localparam int ROUNDS_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : count_pkg

// File: rtl/up_counter.sv
// Free-running modulo-2^WIDTH up-counter with synchronous clear and enable.
module up_counter
  import count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: default assignment first so every path assigns count_d; no latch.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == {WIDTH{1'b1}});

endmodule : up_counter

// File: rtl/count_sequencer.sv
// Runs the up-counter for a requested number of full wrap rounds with a
// start/busy/done handshake, plus pause and abort.
module count_sequencer
  import count_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ROUNDS_W = ROUNDS_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ROUNDS_W-1:0] rounds,
  input  logic                pause,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic [ROUNDS_W-1:0] round_idx,
  output logic                busy,
  output logic                wrap,
  output logic                done
);

  state_e              state_q, state_d;
  logic [ROUNDS_W-1:0] rounds_q, rounds_d;
  logic [ROUNDS_W-1:0] round_idx_q, round_idx_d;
  logic                busy_q, busy_d;
  logic                wrap_q, wrap_d;
  logic                done_q, done_d;

  logic cnt_en;
  logic cnt_clr;
  logic at_max;

  up_counter #(.WIDTH(WIDTH)) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .count  (count),
    .at_max (at_max)
  );

  always_comb begin
    state_d     = state_q;
    rounds_d    = rounds_q;
    round_idx_d = round_idx_q;
    wrap_d      = 1'b0;
    done_d      = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A zero-round request would never complete, so it is dropped.
        if (start && (rounds != '0)) begin
          state_d     = RUN;
          rounds_d    = rounds;
          round_idx_d = '0;
          cnt_clr     = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_d     = IDLE;
          round_idx_d = '0;
          cnt_clr     = 1'b1;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (at_max) begin
            wrap_d      = 1'b1;
            round_idx_d = round_idx_q + 1'b1;
            if (round_idx_q == rounds_q - 1'b1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rounds_q    <= '0;
      round_idx_q <= '0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      round_idx_q <= round_idx_d;
      busy_q      <= busy_d;
      wrap_q      <= wrap_d;
      done_q      <= done_d;
    end
  end

  assign round_idx = round_idx_q;
  assign busy      = busy_q;
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against an increment-count model of the sequencer.
module tb_count_sequencer;
  import count_pkg::*;

  localparam int W    = WIDTH_DEF;
  localparam int RW   = ROUNDS_W_DEF;
  localparam int SPAN = 1 << W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [RW-1:0] rounds;
  logic          pause;
  logic          abort;
  logic [W-1:0]  count;
  logic [RW-1:0] round_idx;
  logic          busy;
  logic          wrap;
  logic          done;

  int n_checks;
  int n_errors;
  bit chk_en;

  count_sequencer #(.WIDTH(W), .ROUNDS_W(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rounds    (rounds),
    .pause     (pause),
    .abort     (abort),
    .count     (count),
    .round_idx (round_idx),
    .busy      (busy),
    .wrap      (wrap),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is just a tally of increments n toward a target of R*SPAN.
  bit m_running;
  int m_n;
  int m_r;
  int m_idx_hold;
  bit m_wrap;
  bit m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_running  = 0;
      m_n        = 0;
      m_r        = 0;
      m_idx_hold = 0;
      m_wrap     = 0;
      m_done     = 0;
    end else begin
      bit was_done;
      was_done = m_done;
      m_wrap   = 0;
      m_done   = 0;
      if (m_running) begin
        if (abort) begin
          m_running  = 0;
          m_idx_hold = 0;
        end else if (!pause) begin
          m_n++;
          if (m_n % SPAN == 0) m_wrap = 1;
          if (m_n == m_r * SPAN) begin
            m_running  = 0;
            m_done     = 1;
            m_idx_hold = m_r;
          end
        end
      end else if (!was_done && start && rounds != 0) begin
        m_running = 1;
        m_n       = 0;
        m_r       = int'(rounds);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("count",     32'(count),     m_running ? 32'(m_n % SPAN) : 32'd0);
      check("round_idx", 32'(round_idx), m_running ? 32'(m_n / SPAN) : 32'(m_idx_hold));
      check("busy",      32'(busy),      32'(m_running));
      check("wrap",      32'(wrap),      32'(m_wrap));
      check("done",      32'(done),      32'(m_done));
    end
  end

  task automatic run_measure(input int r, input bit do_pause, input bit poke,
                             output int k, output int wraps);
    int pc;
    pc    = 0;
    k     = 0;
    wraps = 0;
    start  = 1'b1;
    rounds = RW'(r);
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && k < 1000) begin
      if (!do_pause && !poke) check("run_count", 32'(count), 32'(k % SPAN));
      if (do_pause && count == 2 && pc < 4) begin
        pause = 1'b1;
        pc++;
      end else begin
        pause = 1'b0;
      end
      if (poke && k == 3) begin
        start  = 1'b1;
        rounds = RW'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
      if (wrap === 1'b1) wraps++;
    end
    pause = 1'b0;
    start = 1'b0;
    check("done_busy_low", 32'(busy), 32'd0);
    check("final_wrap",    32'(wrap), 32'd1);
    if (poke) begin
      start  = 1'b1;
      rounds = RW'(2);
      @(negedge clk);
      start = 1'b0;
      check("start_in_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int k;
    int wraps;
    int seen;
    n_checks = 0;
    n_errors = 0;
    chk_en   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rounds   = '0;
    pause    = 1'b0;
    abort    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    rst_n  = 1'b1;
    chk_en = 1;
    @(negedge clk);

    // Basic run.
    run_measure(1, 0, 0, k, wraps);
    check("basic_len", 32'(k), 32'd8);
    check("basic_wraps", 32'(wraps), 32'd1);
    @(negedge clk);
    check("basic_busy_after", 32'(busy), 32'd0);

    // Multi-round; round_idx holds after completion.
    run_measure(3, 0, 0, k, wraps);
    check("multi_len", 32'(k), 32'd24);
    check("multi_wraps", 32'(wraps), 32'd3);
    repeat (2) @(negedge clk);
    check("multi_idx_hold", 32'(round_idx), 32'd3);

    // Pause in IDLE has no effect, then a paused run.
    pause = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b0;
    check("idle_pause_busy", 32'(busy), 32'd0);
    run_measure(1, 1, 0, k, wraps);
    check("pause_len", 32'(k), 32'd12);
    @(negedge clk);

    // Abort at count 5 of round 0.
    start  = 1'b1;
    rounds = RW'(2);
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (count != 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach5", 32'(count), 32'd5);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy",  32'(busy),      32'd0);
    check("abort_count", 32'(count),     32'd0);
    check("abort_idx",   32'(round_idx), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_measure(1, 0, 0, k, wraps);
    check("after_abort_len", 32'(k), 32'd8);
    @(negedge clk);

    // Ignored starts.
    start  = 1'b1;
    rounds = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("zero_rounds_busy", 32'(busy), 32'd0);
    check("zero_rounds_done", 32'(done), 32'd0);
    run_measure(1, 0, 1, k, wraps);
    check("poke_len", 32'(k), 32'd8);
    repeat (3) @(negedge clk);
    check("poke_no_second_run", 32'(busy), 32'd0);

    // Asynchronous reset mid-run, between edges.
    start  = 1'b1;
    rounds = RW'(2);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_count", 32'(count),     32'd0);
    check("areset_idx",   32'(round_idx), 32'd0);
    check("areset_busy",  32'(busy),      32'd0);
    check("areset_wrap",  32'(wrap),      32'd0);
    check("areset_done",  32'(done),      32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("areset_quiet", 32'(seen), 32'd0);

    // Random traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 9) == 0);
      rounds = RW'($urandom_range(0, 3));
      pause  = ($urandom_range(0, 4) == 0);
      abort  = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences the free-running up-counter datapath: runs it for a programmed number of full wrap rounds after a start request, supports pause and abort, and reports completion with a one-cycle done pulse. It sits between the testbench or host control logic and the counter. It replaces open-ended "clock it N times" stimulus with a start/busy/done handshake usable by other on-chip blocks.

## Interface

- WIDTH, 3, counter width; one round = 2^WIDTH increments.
- ROUNDS_W, 4, width of the round-count request.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- rounds  in  ROUNDS_W  number of rounds to run; sampled with start.
- pause  in  1  stall counting while high, RUN only.
- abort  in  1  terminate the run; RUN only.
- count  out  WIDTH  current counter value.
- round_idx  out  ROUNDS_W  rounds completed in the current run.
- busy  out  1  high while in RUN.
- wrap  out  1  one-cycle pulse after count wraps MAX→0.
- done  out  1  one-cycle pulse on normal completion.

## Operation

- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** state=IDLE, count=0, round_idx=0, rounds_q=0, busy=0, wrap=0, done=0.
- **IDLE:**
  - start=1 and rounds≠0 → RUN. Latch rounds_q=rounds; clear count and round_idx.
  - start=1 with rounds=0 is ignored; the block stays in IDLE with no pulse.
- **RUN, priority order:**
  - abort=1 → IDLE. Clears count and round_idx; no done, no wrap.
  - pause=1 → hold all state.
  - Otherwise count ← count+1, modulo 2^WIDTH.
- **Wrap in RUN** (count==MAX, unpaused):
  - count ← 0, wrap=1 next cycle, round_idx ← round_idx+1.
  - If round_idx==rounds_q−1, go to DONE.
- **DONE:** done=1 and busy=0 for exactly one cycle, then IDLE. count=0; round_idx holds rounds_q until the next start.
- **start while busy or in DONE:** ignored; not queued.
- **Arithmetic:** round_idx compare uses ROUNDS_W bits. With ROUNDS_W=4, rounds=15 gives a maximum of 15×8=120 increments at WIDTH=3.
- **Reset mid-run:** immediate return to the reset values above; no done pulse.

## Timing

- All outputs are registered; there are no combinational input→output paths.
- Edge E0 samples start: busy=1 and count=0 from E0.
- Edges E1..E(R·2^WIDTH) increment count.
- done=1 in the cycle after edge E(R·2^WIDTH), with busy=0 in that same cycle. Each paused cycle adds one cycle.
- wrap=1 in the cycle after each MAX→0 transition. On the final round, wrap and done are high in the same cycle.
- abort sampled at edge Ea: busy=0 and count=0 from Ea.
- pause is sampled per edge with no extra latency.

## Structure

- **Shared package `count_pkg`:** state typedef (IDLE/RUN/DONE encoding) and the default WIDTH and ROUNDS_W constants.
- **Sub-module `up_counter`:** the counter datapath. It has inputs clk, rst_n, en and clr; outputs count[WIDTH] and at_max.
- **count_sequencer** instantiates up_counter and holds the FSM, rounds_q, round_idx, and the wrap/done registers.

## Test plan

- **Basic run:** reset, start with rounds=1 → count 0..7 over 8 cycles; wrap and done high together exactly 8 cycles after the start edge; busy low afterwards.
- **Multi-round:** rounds=3 → exactly 3 wrap pulses; round_idx steps 1,2,3; done after 24 cycles; round_idx holds 3 in IDLE.
- **Pause:** rounds=1, pause high for 4 cycles starting at count=2 → count holds at 2; done delayed to 12 cycles; pause while in IDLE has no effect.
- **Abort:** rounds=2, abort at count=5 of round 0 → busy=0 and count=0 at the next edge; no done; a following start runs normally.
- **Ignored starts:** start with rounds=0 → stays IDLE with no pulses; start pulsed mid-run and during DONE → run length unchanged, no second run.
- **Async reset:** assert rst_n low mid-run, between clock edges → all outputs go to reset values immediately, without waiting for a clock edge; no done pulse after release.
